// File: rtl/blur_frame_scheduler_if.sv
// Handshake bundle between the blur frame scheduler and its capture engine,
// blur engine and output consumer.
// Handshake contract: cap_start/blur_start and cap_done/blur_done are
// single-cycle pulses; a done pulse is honoured only while the matching
// channel is busy; out_valid holds until out_ack is sampled high and drops
// on the following cycle.
interface blur_frame_scheduler_if #(
  parameter int SEQ_W = 8,
  parameter int CNT_W = 16
) ();
  logic             enable;
  logic             frame_tick;
  logic             cap_start;
  logic             cap_buf;
  logic             cap_done;
  logic             blur_start;
  logic             blur_buf;
  logic             blur_done;
  logic             out_valid;
  logic             out_ack;
  logic [SEQ_W-1:0] frame_seq;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] drop_count;

  modport master (
    input  enable, frame_tick, cap_done, blur_done, out_ack,
    output cap_start, cap_buf, blur_start, blur_buf, out_valid, frame_seq,
           busy, timeout_err, drop_count
  );

  modport slave (
    output enable, frame_tick, cap_done, blur_done, out_ack,
    input  cap_start, cap_buf, blur_start, blur_buf, out_valid, frame_seq,
           busy, timeout_err, drop_count
  );
endinterface

// File: rtl/blur_frame_scheduler.sv
// Ping-pong frame scheduler: two input frame buffers feed a 3x3 blur engine
// that writes a single output buffer. Captures go to the lowest EMPTY buffer,
// blur always consumes the oldest FULL buffer, overruns drop frames and hung
// engines are aborted after TIMEOUT_CYCLES busy cycles.
// Optional feature: define FRAME_DROP_CNT_EN to build the saturating
// dropped-frame counter; otherwise drop_count is tied to zero.
// dbg_o = {buf1_state, buf0_state, blur_channel, cap_channel}.
module blur_frame_scheduler #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SEQ_W          = 8,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  blur_frame_scheduler_if.master bus,
  output logic [5:0]            dbg_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_CAP   = 2'd1,
    BUF_FULL  = 2'd2,
    BUF_BLUR  = 2'd3
  } buf_st_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } ch_st_e;

  buf_st_e          buf_q [2];
  buf_st_e          buf_d [2];
  logic [SEQ_W-1:0] tag_q [2];
  logic [SEQ_W-1:0] tag_d [2];
  ch_st_e           cap_q, cap_d, blur_q, blur_d;
  logic             cap_buf_q, cap_buf_d, blur_buf_q, blur_buf_d;
  logic             cap_start_q, cap_start_d, blur_start_q, blur_start_d;
  logic             oldest_q, oldest_d;
  logic [SEQ_W-1:0] seq_q, seq_d, frame_seq_q, frame_seq_d;
  logic             out_valid_q, out_valid_d;
  logic [TW-1:0]    cap_cnt_q, cap_cnt_d, blur_cnt_q, blur_cnt_d;
  logic             err_q, err_d;

  logic             any_empty;
  logic             free_idx;
  logic             any_full;

  assign any_empty = (buf_q[0] == BUF_EMPTY) || (buf_q[1] == BUF_EMPTY);
  assign free_idx  = (buf_q[0] == BUF_EMPTY) ? 1'b0 : 1'b1;
  assign any_full  = (buf_q[0] == BUF_FULL) || (buf_q[1] == BUF_FULL);

  // State register for buffers, channels, timers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0]     <= BUF_EMPTY;
      buf_q[1]     <= BUF_EMPTY;
      tag_q[0]     <= '0;
      tag_q[1]     <= '0;
      cap_q        <= CH_IDLE;
      blur_q       <= CH_IDLE;
      cap_buf_q    <= 1'b0;
      blur_buf_q   <= 1'b0;
      cap_start_q  <= 1'b0;
      blur_start_q <= 1'b0;
      oldest_q     <= 1'b0;
      seq_q        <= '0;
      frame_seq_q  <= '0;
      out_valid_q  <= 1'b0;
      cap_cnt_q    <= '0;
      blur_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      buf_q[0]     <= buf_d[0];
      buf_q[1]     <= buf_d[1];
      tag_q[0]     <= tag_d[0];
      tag_q[1]     <= tag_d[1];
      cap_q        <= cap_d;
      blur_q       <= blur_d;
      cap_buf_q    <= cap_buf_d;
      blur_buf_q   <= blur_buf_d;
      cap_start_q  <= cap_start_d;
      blur_start_q <= blur_start_d;
      oldest_q     <= oldest_d;
      seq_q        <= seq_d;
      frame_seq_q  <= frame_seq_d;
      out_valid_q  <= out_valid_d;
      cap_cnt_q    <= cap_cnt_d;
      blur_cnt_q   <= blur_cnt_d;
      err_q        <= err_d;
    end
  end

  // Next-state: launch decisions use registered state only, so a buffer freed
  // or filled this cycle is not visible to a launch until the next cycle.
  always_comb begin
    buf_d        = buf_q;
    tag_d        = tag_q;
    cap_d        = cap_q;
    blur_d       = blur_q;
    cap_buf_d    = cap_buf_q;
    blur_buf_d   = blur_buf_q;
    cap_start_d  = 1'b0;
    blur_start_d = 1'b0;
    oldest_d     = oldest_q;
    seq_d        = seq_q;
    frame_seq_d  = frame_seq_q;
    out_valid_d  = out_valid_q;
    cap_cnt_d    = cap_cnt_q;
    blur_cnt_d   = blur_cnt_q;
    err_d        = err_q;

    // Capture launch into the lowest EMPTY buffer; the frame gets the next tag.
    if (bus.frame_tick && bus.enable && (cap_q == CH_IDLE) && any_empty) begin
      cap_start_d     = 1'b1;
      cap_d           = CH_BUSY;
      cap_buf_d       = free_idx;
      buf_d[free_idx] = BUF_CAP;
      tag_d[free_idx] = seq_q;
      seq_d           = seq_q + 1'b1;
      cap_cnt_d       = '0;
    end

    // Blur launch on the oldest FULL buffer, only while the output is free.
    if ((blur_q == CH_IDLE) && !out_valid_q) begin
      if (buf_q[oldest_q] == BUF_FULL) begin
        blur_start_d    = 1'b1;
        blur_d          = CH_BUSY;
        blur_buf_d      = oldest_q;
        buf_d[oldest_q] = BUF_BLUR;
        blur_cnt_d      = '0;
      end else if (buf_q[~oldest_q] == BUF_FULL) begin
        blur_start_d     = 1'b1;
        blur_d           = CH_BUSY;
        blur_buf_d       = ~oldest_q;
        buf_d[~oldest_q] = BUF_BLUR;
        blur_cnt_d       = '0;
      end
    end

    // Capture completion or abort; a done on the last cycle still wins.
    if (cap_q == CH_BUSY) begin
      if (bus.cap_done) begin
        buf_d[cap_buf_q] = BUF_FULL;
        cap_d            = CH_IDLE;
        oldest_d         = (buf_q[~cap_buf_q] == BUF_FULL) ? ~cap_buf_q : cap_buf_q;
      end else if (cap_cnt_q == TO_LAST) begin
        buf_d[cap_buf_q] = BUF_EMPTY;
        cap_d            = CH_IDLE;
        err_d            = 1'b1;
      end else begin
        cap_cnt_d = cap_cnt_q + 1'b1;
      end
    end

    // Consumer releases the output buffer.
    if (out_valid_q && bus.out_ack) begin
      out_valid_d = 1'b0;
    end

    // Blur completion publishes the frame; an abort publishes nothing.
    if (blur_q == CH_BUSY) begin
      if (bus.blur_done) begin
        buf_d[blur_buf_q] = BUF_EMPTY;
        blur_d            = CH_IDLE;
        out_valid_d       = 1'b1;
        frame_seq_d       = tag_q[blur_buf_q];
      end else if (blur_cnt_q == TO_LAST) begin
        buf_d[blur_buf_q] = BUF_EMPTY;
        blur_d            = CH_IDLE;
        err_d             = 1'b1;
      end else begin
        blur_cnt_d = blur_cnt_q + 1'b1;
      end
    end
  end

`ifdef FRAME_DROP_CNT_EN
  logic             drop_evt;
  logic [CNT_W-1:0] drop_q;

  assign drop_evt = bus.frame_tick && bus.enable && ((cap_q == CH_BUSY) || !any_empty);

  // Saturating count of frames lost to overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_evt && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = '0;
`endif

  assign bus.cap_start   = cap_start_q;
  assign bus.cap_buf     = cap_buf_q;
  assign bus.blur_start  = blur_start_q;
  assign bus.blur_buf    = blur_buf_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_seq   = frame_seq_q;
  assign bus.timeout_err = err_q;
  assign bus.busy        = (cap_q == CH_BUSY) || (blur_q == CH_BUSY) || any_full || out_valid_q;
  assign dbg_o           = {buf_q[1], buf_q[0], blur_q, cap_q};
endmodule

// File: tb/tb_blur_frame_scheduler.sv
// Bench for blur_frame_scheduler: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model
// (buffer states plus a FIFO of completed frames in arrival order).
module tb_blur_frame_scheduler;
  localparam int TO    = 50;
  localparam int SEQ_W = 8;
  localparam int CNT_W = 16;
  localparam int EMPTY = 0, CAP = 1, FULL = 2, BLUR = 3;
`ifdef FRAME_DROP_CNT_EN
  localparam int EXP_DROP1 = 1;
`else
  localparam int EXP_DROP1 = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] dbg;
  bit         en  = 1'b1;

  always #5 clk = ~clk;

  blur_frame_scheduler_if #(.SEQ_W(SEQ_W), .CNT_W(CNT_W)) bus ();

  blur_frame_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .SEQ_W(SEQ_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .dbg_o(dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_buf [2];
  logic [SEQ_W-1:0] m_tag [2];
  logic [0:0]       exp_q[$];   // FULL buffers in completion order
  bit               m_cap_busy, m_blur_busy, m_cap_start, m_blur_start;
  bit               m_out_valid, m_err;
  logic             m_cap_buf, m_blur_buf;
  logic [SEQ_W-1:0] m_seq, m_frame_seq;
  int               m_drops;
  int               m_cyc = 0;
  int               m_cap_t0, m_blur_t0;

  task automatic model_reset();
    m_buf[0] = EMPTY; m_buf[1] = EMPTY;
    m_tag[0] = '0;    m_tag[1] = '0;
    exp_q.delete();
    m_cap_busy = 0; m_blur_busy = 0; m_cap_start = 0; m_blur_start = 0;
    m_out_valid = 0; m_err = 0; m_cap_buf = 0; m_blur_buf = 0;
    m_seq = '0; m_frame_seq = '0; m_drops = 0; m_cap_t0 = 0; m_blur_t0 = 0;
  endtask

  // Advance the model from cycle m_cyc to m_cyc+1 given this cycle's inputs.
  task automatic model_step(input bit tk, input bit cd, input bit bd, input bit ack);
    bit o_cap, o_blur, o_ov;
    int fb;
    if (rst) begin
      model_reset();
      m_cyc++;
      return;
    end
    o_cap = m_cap_busy; o_blur = m_blur_busy; o_ov = m_out_valid;
    m_cap_start = 0; m_blur_start = 0;
    if (tk && en) begin
      fb = (m_buf[0] == EMPTY) ? 0 : (m_buf[1] == EMPTY) ? 1 : -1;
      if (o_cap || fb < 0) begin
`ifdef FRAME_DROP_CNT_EN
        if (m_drops < (2**CNT_W) - 1) m_drops++;
`endif
      end else begin
        m_buf[fb] = CAP; m_tag[fb] = m_seq; m_seq = m_seq + 1'b1;
        m_cap_busy = 1; m_cap_buf = fb[0]; m_cap_start = 1; m_cap_t0 = m_cyc + 1;
      end
    end
    if (!o_blur && !o_ov && exp_q.size() > 0) begin
      fb = int'(exp_q.pop_front());
      m_buf[fb] = BLUR; m_blur_busy = 1; m_blur_buf = fb[0];
      m_blur_start = 1; m_blur_t0 = m_cyc + 1;
    end
    if (o_cap) begin
      if (cd) begin
        m_buf[m_cap_buf] = FULL; exp_q.push_back(m_cap_buf); m_cap_busy = 0;
      end else if (m_cyc - m_cap_t0 == TO - 1) begin
        m_buf[m_cap_buf] = EMPTY; m_cap_busy = 0; m_err = 1;
      end
    end
    if (o_ov && ack) m_out_valid = 0;
    if (o_blur) begin
      if (bd) begin
        m_buf[m_blur_buf] = EMPTY; m_out_valid = 1;
        m_frame_seq = m_tag[m_blur_buf]; m_blur_busy = 0;
      end else if (m_cyc - m_blur_t0 == TO - 1) begin
        m_buf[m_blur_buf] = EMPTY; m_blur_busy = 0; m_err = 1;
      end
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    bit exp_busy;
    exp_busy = m_cap_busy || m_blur_busy || m_out_valid || (m_buf[0] == FULL) || (m_buf[1] == FULL);
    check_eq("cap_start", bus.cap_start, m_cap_start);
    if (m_cap_busy) check_eq("cap_buf", bus.cap_buf, m_cap_buf);
    check_eq("blur_start", bus.blur_start, m_blur_start);
    if (m_blur_busy) check_eq("blur_buf", bus.blur_buf, m_blur_buf);
    check_eq("out_valid", bus.out_valid, m_out_valid);
    check_eq("frame_seq", bus.frame_seq, m_frame_seq);
    check_eq("busy", bus.busy, exp_busy);
    check_eq("timeout_err", bus.timeout_err, m_err);
    check_eq("drop_count", bus.drop_count, CNT_W'(m_drops));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive inputs, advance model, then check next cycle.
  task automatic step(input bit tk, input bit cd, input bit bd, input bit ack);
    bus.enable     = en;
    bus.frame_tick = tk;
    bus.cap_done   = cd;
    bus.blur_done  = bd;
    bus.out_ack    = ack;
    model_step(tk, cd, bd, ack);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  int cap_due  = -1;
  int blur_due = -1;

  // ---------------- stimulus ----------------
  initial begin
    bus.enable = 1'b1; bus.frame_tick = 1'b0; bus.cap_done = 1'b0;
    bus.blur_done = 1'b0; bus.out_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    check_eq("rst_cap_buf", bus.cap_buf, 0);
    check_eq("rst_blur_buf", bus.blur_buf, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_dbg", dbg, 0);

    // Basic latency, second capture during blur, overrun drop, ack-to-blur.
    step(1, 0, 0, 0);                                   // t0+1
    check_eq("t1_cap_start", bus.cap_start, 1);
    check_eq("t1_cap_buf", bus.cap_buf, 0);
    idle(9);                                            // t0+10
    step(0, 1, 0, 0);                                   // t0+11
    step(0, 0, 0, 0);                                   // t0+12
    check_eq("t1_blur_start", bus.blur_start, 1);
    check_eq("t1_blur_buf", bus.blur_buf, 0);
    step(1, 0, 0, 0);                                   // t0+13
    check_eq("t2_cap_start", bus.cap_start, 1);
    check_eq("t2_cap_buf", bus.cap_buf, 1);
    idle(3);
    step(0, 1, 0, 0);                                   // t0+17
    idle(3);                                            // t0+20
    step(0, 0, 1, 0);                                   // t0+21
    check_eq("t1_out_valid", bus.out_valid, 1);
    check_eq("t1_frame_seq", bus.frame_seq, 0);
    step(1, 0, 0, 0);
    check_eq("t3_cap_buf", bus.cap_buf, 0);
    idle(2);
    step(0, 1, 0, 0);                                   // both buffers FULL
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);                                   // overrun tick
    check_eq("t3_no_cap_start", bus.cap_start, 0);
    check_eq("t3_drop_count", bus.drop_count, EXP_DROP1);
    step(0, 0, 0, 1);                                   // ack at t
    check_eq("t4_out_valid_clr", bus.out_valid, 0);
    check_eq("t4_no_early_blur", bus.blur_start, 0);
    step(0, 0, 0, 0);                                   // t+2
    check_eq("t4_blur_start", bus.blur_start, 1);
    check_eq("t4_blur_buf_old", bus.blur_buf, 1);
    idle(3);
    step(0, 0, 1, 0);
    check_eq("t2_frame_seq1", bus.frame_seq, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check_eq("t2_blur_buf0", bus.blur_buf, 0);
    idle(2);
    step(0, 0, 1, 0);
    check_eq("t3_frame_seq2", bus.frame_seq, 2);
    step(0, 0, 0, 1);

    // Blur engine hangs: abort after TO cycles, buffer reused.
    do_reset();
    step(1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_eq("t5_blur_start", bus.blur_start, 1);
    idle(TO - 1);
    check_eq("t5_err_before", bus.timeout_err, 0);
    step(0, 0, 0, 0);
    check_eq("t5_err_after", bus.timeout_err, 1);
    check_eq("t5_no_out_valid", bus.out_valid, 0);
    step(1, 0, 0, 0);
    check_eq("t5_reuse_start", bus.cap_start, 1);
    check_eq("t5_reuse_buf", bus.cap_buf, 0);
    step(0, 1, 0, 0);
    idle(2);
    step(0, 0, 1, 0);
    check_eq("t5_frame_seq", bus.frame_seq, 1);
    step(0, 0, 0, 1);

    // Reset in the middle of a capture and a blur.
    step(1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    do_reset();
    check_eq("t6_cap_start", bus.cap_start, 0);
    check_eq("t6_blur_start", bus.blur_start, 0);
    check_eq("t6_busy", bus.busy, 0);
    check_eq("t6_err", bus.timeout_err, 0);
    check_eq("t6_cap_buf", bus.cap_buf, 0);
    step(1, 0, 0, 0);
    check_eq("t6_cap_buf0", bus.cap_buf, 0);
    step(0, 1, 0, 0);
    idle(2);
    step(0, 0, 1, 0);
    check_eq("t6_frame_seq0", bus.frame_seq, 0);
    step(0, 0, 0, 1);

    // Randomized traffic with emulated engines (some hang or answer late).
    for (int c = 0; c < 4000; c++) begin
      bit tk, cd, bd, ack;
      int r;
      if (m_cap_start) begin
        r = $urandom_range(0, 9);
        cap_due = (r == 0) ? -1 : (r == 1) ? m_cyc + 60 : m_cyc + $urandom_range(0, 20);
      end
      if (m_blur_start) begin
        r = $urandom_range(0, 9);
        blur_due = (r == 0) ? -1 : (r == 1) ? m_cyc + 60 : m_cyc + $urandom_range(0, 20);
      end
      cd  = (m_cyc == cap_due)  || ($urandom_range(0, 40) == 0);
      bd  = (m_cyc == blur_due) || ($urandom_range(0, 40) == 0);
      tk  = ($urandom_range(0, 11) == 0);
      ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      rst = ($urandom_range(0, 999) == 0);
      step(tk, cd, bd, ack);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
